// File: rtl/pe_multi_filter_mac.sv
// Multi-filter 1D convolution processing element.
// Buffers one IF window, then for each configured filter runs one MAC per tap
// (optionally seeded from an incoming psum) and emits one psum per filter.
module pe_multi_filter_mac #(
  parameter int unsigned IF_WIDTH      = 8,
  parameter int unsigned FILT_WIDTH    = 8,
  parameter int unsigned FILT_ADDR_LEN = 4,
  parameter int unsigned NF_LOG        = 2,
  parameter int unsigned PSUM_WIDTH    = 20
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_ld,
  input  logic [FILT_ADDR_LEN-1:0]        cfg_filt_len,
  input  logic [NF_LOG:0]                 cfg_num_filt,
  input  logic                            cfg_psum_mode,
  input  logic                            cfg_sat,
  input  logic                            filt_wen,
  input  logic [NF_LOG+FILT_ADDR_LEN-1:0] filt_waddr,
  input  logic [FILT_WIDTH-1:0]           filt_wdata,
  input  logic                            win_valid,
  output logic                            win_ready,
  input  logic [IF_WIDTH-1:0]             win_data,
  input  logic                            psum_in_valid,
  output logic                            psum_in_ready,
  input  logic [PSUM_WIDTH-1:0]           psum_in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PSUM_WIDTH-1:0]           out_data,
  output logic [NF_LOG-1:0]               out_filt_idx,
  output logic                            busy
);

  localparam int unsigned NFW          = NF_LOG + 1;
  localparam int unsigned NUM_FILT_MAX = 1 << NF_LOG;
  localparam int unsigned WIN_DEPTH    = 1 << FILT_ADDR_LEN;
  localparam int unsigned SCR_AW       = NF_LOG + FILT_ADDR_LEN;
  localparam int unsigned SCR_DEPTH    = 1 << SCR_AW;
  localparam int unsigned PROD_W       = IF_WIDTH + FILT_WIDTH;
  localparam int unsigned SUM_W        = PSUM_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEED = 3'd2,
    MAC  = 3'd3,
    EMIT = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [FILT_ADDR_LEN-1:0] filt_len;
  logic [NFW-1:0]           num_filt;
  logic                     psum_mode;
  logic                     sat;

  logic [FILT_ADDR_LEN-1:0] tap_cnt;
  logic [NF_LOG-1:0]        f_idx;
  logic [PSUM_WIDTH-1:0]    acc;

  logic [IF_WIDTH-1:0]   window   [WIN_DEPTH];
  logic [FILT_WIDTH-1:0] filt_scr [SCR_DEPTH];

  logic                     win_hs, psum_hs, out_hs;
  logic                     cfg_take;
  logic [FILT_ADDR_LEN-1:0] cfg_len_eff;
  logic [NFW-1:0]           cfg_nf_eff;
  logic [FILT_ADDR_LEN-1:0] len_use;
  logic                     mode_use;
  logic                     last_tap, last_filt;
  logic [PROD_W-1:0]        prod;
  logic [SUM_W-1:0]         sum;
  logic [PSUM_WIDTH-1:0]    mac_val;
  logic [FILT_ADDR_LEN-1:0] win_widx;

  // Handshakes, clamped configuration and MAC datapath
  always_comb begin
    win_hs   = win_valid && win_ready;
    psum_hs  = psum_in_valid && psum_in_ready;
    out_hs   = out_valid && out_ready;
    cfg_take = cfg_ld && (state == IDLE);

    cfg_len_eff = (cfg_filt_len == '0) ? FILT_ADDR_LEN'(1) : cfg_filt_len;
    if (cfg_num_filt == '0) begin
      cfg_nf_eff = NFW'(1);
    end else if (cfg_num_filt > NFW'(NUM_FILT_MAX)) begin
      cfg_nf_eff = NFW'(NUM_FILT_MAX);
    end else begin
      cfg_nf_eff = cfg_num_filt;
    end

    // A configuration load in the same IDLE cycle as the first window word applies to that window
    len_use  = cfg_take ? cfg_len_eff : filt_len;
    mode_use = cfg_take ? cfg_psum_mode : psum_mode;

    last_tap  = (tap_cnt == (filt_len - FILT_ADDR_LEN'(1)));
    last_filt = ({1'b0, f_idx} == (num_filt - NFW'(1)));

    prod    = PROD_W'(window[tap_cnt]) * PROD_W'(filt_scr[{f_idx, tap_cnt}]);
    sum     = {1'b0, acc} + SUM_W'(prod);
    mac_val = (sat && sum[PSUM_WIDTH]) ? {PSUM_WIDTH{1'b1}} : sum[PSUM_WIDTH-1:0];

    win_widx = (state == IDLE) ? '0 : tap_cnt;
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (win_hs) state_nxt = (len_use == FILT_ADDR_LEN'(1)) ? SEED : LOAD;
      LOAD: if (win_hs && last_tap) state_nxt = SEED;
      SEED: if (!psum_mode || psum_hs) state_nxt = MAC;
      MAC:  if (last_tap) state_nxt = EMIT;
      EMIT: if (out_hs) state_nxt = last_filt ? IDLE : SEED;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, configuration, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      filt_len      <= FILT_ADDR_LEN'(1);
      num_filt      <= NFW'(1);
      psum_mode     <= 1'b0;
      sat           <= 1'b0;
      tap_cnt       <= '0;
      f_idx         <= '0;
      acc           <= '0;
      win_ready     <= 1'b0;
      psum_in_ready <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_filt_idx  <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      win_ready     <= (state_nxt == IDLE) || (state_nxt == LOAD);
      psum_in_ready <= (state_nxt == SEED) && mode_use;
      out_valid     <= (state_nxt == EMIT);
      busy          <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          f_idx <= '0;
          if (cfg_take) begin
            filt_len  <= cfg_len_eff;
            num_filt  <= cfg_nf_eff;
            psum_mode <= cfg_psum_mode;
            sat       <= cfg_sat;
          end
          if (win_hs) tap_cnt <= FILT_ADDR_LEN'(1);
        end
        LOAD: begin
          if (win_hs) tap_cnt <= tap_cnt + FILT_ADDR_LEN'(1);
        end
        SEED: begin
          tap_cnt <= '0;
          if (!psum_mode) begin
            acc <= '0;
          end else if (psum_hs) begin
            acc <= psum_in_data;
          end
        end
        MAC: begin
          acc     <= mac_val;
          tap_cnt <= tap_cnt + FILT_ADDR_LEN'(1);
          if (last_tap) begin
            out_data     <= mac_val;
            out_filt_idx <= f_idx;
          end
        end
        EMIT: begin
          if (out_hs) f_idx <= last_filt ? '0 : (f_idx + NF_LOG'(1));
        end
        default: ;
      endcase
    end
  end

  // Window register file; contents are discarded by reset via the FSM
  always_ff @(posedge clk) begin
    if (win_hs) window[win_widx] <= win_data;
  end

  // Filter scratch, writable only while idle; not reset
  always_ff @(posedge clk) begin
    if (filt_wen && (state == IDLE)) filt_scr[filt_waddr] <= filt_wdata;
  end

endmodule

// File: tb/tb_pe_multi_filter_mac.sv
// Directed, table-driven bench for pe_multi_filter_mac (PSUM_WIDTH=16).
module tb_pe_multi_filter_mac;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_ld;
  logic [3:0]    cfg_filt_len;
  logic [2:0]    cfg_num_filt;
  logic          cfg_psum_mode;
  logic          cfg_sat;
  logic          filt_wen;
  logic [5:0]    filt_waddr;
  logic [7:0]    filt_wdata;
  logic          win_valid;
  logic          win_ready;
  logic [7:0]    win_data;
  logic          psum_in_valid;
  logic          psum_in_ready;
  logic [PW-1:0] psum_in_data;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic [1:0]    out_filt_idx;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  pe_multi_filter_mac #(
    .IF_WIDTH(8), .FILT_WIDTH(8), .FILT_ADDR_LEN(4), .NF_LOG(2), .PSUM_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_ld(cfg_ld), .cfg_filt_len(cfg_filt_len), .cfg_num_filt(cfg_num_filt),
    .cfg_psum_mode(cfg_psum_mode), .cfg_sat(cfg_sat),
    .filt_wen(filt_wen), .filt_waddr(filt_waddr), .filt_wdata(filt_wdata),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in_data(psum_in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_filt_idx(out_filt_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]            len;
    logic [2:0]            nf;
    logic                  mode;
    logic                  sat;
    logic [3:0][3:0][7:0]  taps;   // [filter][tap]
    logic [3:0][7:0]       win;
    logic [15:0]           seed;
    logic [3:0][15:0]      expv;   // expected psum per filter
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic set_cfg(input int len, input int nf, input logic mode, input logic s);
    cfg_ld = 1'b1; cfg_filt_len = 4'(len); cfg_num_filt = 3'(nf);
    cfg_psum_mode = mode; cfg_sat = s;
    @(negedge clk);
    cfg_ld = 1'b0;
  endtask

  task automatic write_tap(input int f, input int t, input int val);
    filt_wen = 1'b1; filt_waddr = 6'(f * 16 + t); filt_wdata = 8'(val);
    @(negedge clk);
    filt_wen = 1'b0;
  endtask

  task automatic send_win(input int d);
    int cnt = 0;
    win_valid = 1'b1; win_data = 8'(d);
    while (!win_ready && cnt < 200) begin @(negedge clk); cnt++; end
    if (!win_ready) check("win_ready_timeout", 32'(win_ready), 32'd1);
    @(negedge clk);
    win_valid = 1'b0;
  endtask

  task automatic send_seed(input int d);
    int cnt = 0;
    psum_in_valid = 1'b1; psum_in_data = PW'(d);
    while (!psum_in_ready && cnt < 200) begin @(negedge clk); cnt++; end
    if (!psum_in_ready) check("psum_ready_timeout", 32'(psum_in_ready), 32'd1);
    @(negedge clk);
    psum_in_valid = 1'b0;
  endtask

  // Wait for a result (out_ready assumed 1), compare, and consume it; elat=0 skips latency check
  task automatic get_out(input string nm, input logic [15:0] ed, input int ei, input int elat);
    int k = 1;
    while (!out_valid && k < 200) begin @(negedge clk); k++; end
    if (!out_valid) begin
      check({nm, "_timeout"}, 32'(out_valid), 32'd1);
    end else begin
      check({nm, "_data"}, 32'(out_data), 32'(ed));
      check({nm, "_idx"}, 32'(out_filt_idx), 32'(ei));
      if (elat != 0) check({nm, "_latency"}, 32'(k), 32'(elat));
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v = vecs[i];
    int lene = (v.len == 0) ? 1 : int'(v.len);
    int nfe  = (v.nf == 0) ? 1 : ((v.nf > 4) ? 4 : int'(v.nf));
    set_cfg(int'(v.len), int'(v.nf), v.mode, v.sat);
    for (int f = 0; f < nfe; f++)
      for (int t = 0; t < lene; t++)
        write_tap(f, t, int'(v.taps[f][t]));
    for (int t = 0; t < lene; t++) send_win(int'(v.win[t]));
    for (int f = 0; f < nfe; f++) begin
      if (v.mode) send_seed(int'(v.seed));
      get_out($sformatf("vec%0d_f%0d", i, f), v.expv[f], f, v.mode ? 0 : lene + 2);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_ld = 0; cfg_filt_len = 0; cfg_num_filt = 0; cfg_psum_mode = 0; cfg_sat = 0;
    filt_wen = 0; filt_waddr = 0; filt_wdata = 0; win_valid = 0; win_data = 0;
    psum_in_valid = 0; psum_in_data = 0; out_ready = 1'b1;

    // Vector table
    for (int i = 0; i < NV; i++) vecs[i] = '0;
    // basic: {1,2,3} . {4,5,6} = 32
    vecs[0].len = 3; vecs[0].nf = 1;
    vecs[0].taps[0] = {8'd0, 8'd3, 8'd2, 8'd1};
    vecs[0].win = {8'd0, 8'd6, 8'd5, 8'd4};
    vecs[0].expv[0] = 16'd32;
    // multi-filter: window {7,9}
    vecs[1].len = 2; vecs[1].nf = 3;
    vecs[1].taps[0] = {8'd0, 8'd0, 8'd1, 8'd1};
    vecs[1].taps[1] = {8'd0, 8'd0, 8'd0, 8'd2};
    vecs[1].taps[2] = {8'd0, 8'd0, 8'd3, 8'd0};
    vecs[1].win = {8'd0, 8'd0, 8'd9, 8'd7};
    vecs[1].expv[0] = 16'd16; vecs[1].expv[1] = 16'd14; vecs[1].expv[2] = 16'd27;
    // saturating, seeded
    vecs[2].len = 2; vecs[2].nf = 1; vecs[2].mode = 1; vecs[2].sat = 1;
    vecs[2].taps[0] = {8'd0, 8'd0, 8'd255, 8'd255};
    vecs[2].win = {8'd0, 8'd0, 8'd255, 8'd255};
    vecs[2].seed = 16'hFFF0;
    vecs[2].expv[0] = 16'hFFFF;
    // wrapping, seeded
    vecs[3] = vecs[2]; vecs[3].sat = 0;
    vecs[3].expv[0] = 16'((32'hFFF0 + 2 * 255 * 255) % 65536);
    // filt_len=0 and num_filt=0 both act as 1
    vecs[4].len = 0; vecs[4].nf = 0;
    vecs[4].taps[0] = {8'd0, 8'd0, 8'd0, 8'd7};
    vecs[4].win = {8'd0, 8'd0, 8'd0, 8'd9};
    vecs[4].expv[0] = 16'd63;
    // num_filt=7 clamps to 4
    vecs[5].len = 1; vecs[5].nf = 7;
    vecs[5].taps[0] = 32'd1; vecs[5].taps[1] = 32'd2; vecs[5].taps[2] = 32'd3; vecs[5].taps[3] = 32'd4;
    vecs[5].win = {8'd0, 8'd0, 8'd0, 8'd10};
    vecs[5].expv = {16'd40, 16'd30, 16'd20, 16'd10};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_win_ready", 32'(win_ready), 0);
    check("rst_psum_in_ready", 32'(psum_in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_filt_idx", 32'(out_filt_idx), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_win_ready", 32'(win_ready), 1);

    // Reset configuration: filt_len=1, num_filt=1, mode 0
    write_tap(0, 0, 3);
    send_win(7);
    get_out("rstcfg", 16'd21, 0, 3);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) run_vec(i);

    // Seeded psum with the seed withheld 4 cycles
    set_cfg(2, 1, 1'b1, 1'b0);
    write_tap(0, 0, 1); write_tap(0, 1, 1);
    send_win(2); send_win(3);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("seed_stall_ready_c%0d", c), 32'(psum_in_ready), 1);
      check($sformatf("seed_stall_noout_c%0d", c), 32'(out_valid), 0);
      @(negedge clk);
    end
    send_seed(100);
    get_out("seeded", 16'd105, 0, 0);

    // Backpressure, plus config/filter writes while busy are ignored
    set_cfg(2, 2, 1'b0, 1'b0);
    write_tap(0, 0, 1); write_tap(0, 1, 1);
    write_tap(1, 0, 2); write_tap(1, 1, 0);
    out_ready = 1'b0;
    send_win(7); send_win(9);
    cfg_ld = 1'b1; cfg_filt_len = 4'd1; cfg_num_filt = 3'd1; cfg_sat = 1'b1;
    filt_wen = 1'b1; filt_waddr = 6'd0; filt_wdata = 8'd99;
    @(negedge clk);
    cfg_ld = 1'b0; filt_wen = 1'b0;
    begin
      int k = 0;
      while (!out_valid && k < 200) begin @(negedge clk); k++; end
      check("bp_out_valid", 32'(out_valid), 1);
    end
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_hold_c%0d", c),
            {13'd0, out_valid, win_ready, out_filt_idx, out_data},
            {13'd0, 1'b1, 1'b0, 2'd0, 16'd16});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    get_out("bp_f1", 16'd14, 1, 4);
    // Readback with the untouched configuration and taps
    send_win(7); send_win(9);
    get_out("rb_f0", 16'd16, 0, 4);
    get_out("rb_f1", 16'd14, 1, 4);

    // Reset in the middle of MAC
    set_cfg(3, 1, 1'b0, 1'b0);
    write_tap(0, 0, 1); write_tap(0, 1, 2); write_tap(0, 2, 3);
    send_win(4); send_win(5); send_win(6);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    set_cfg(1, 1, 1'b0, 1'b0);
    write_tap(0, 0, 11);
    send_win(5);
    get_out("postrst", 16'd55, 0, 3);
    check("postrst_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
